// File: rtl/blit_write_combiner.sv
// Byte-write combiner for the blitter: merges same-word byte writes into masked
// 32-bit writes, queues them in a FWFT FIFO and raises an early stall.
module blit_write_combiner #(
  parameter int FIFO_DEPTH   = 8,
  parameter int STALL_MARGIN = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        p4_write,
  input  logic [25:0] p4_address,
  input  logic [7:0]  p4_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        idle,
  output logic        overflow,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [25:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] STALL_TH = CW'(FIFO_DEPTH - STALL_MARGIN);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_FIRE  = TW'(TIMEOUT - 2);

  logic          acc_valid_q, acc_valid_d;
  logic [23:0]   acc_addr_q, acc_addr_d;
  logic [31:0]   acc_data_q, acc_data_d;
  logic [3:0]    acc_mask_q, acc_mask_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          stall_q, overflow_q;

  logic [23:0]   fifo_addr_q [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [3:0]    fifo_mask_q [FIFO_DEPTH];

  logic          same_word_s, push_s, push_ok_s, pop_s;
  logic [4:0]    shift_s;
  logic [31:0]   merged_data_s, push_data_s;
  logic [3:0]    merged_mask_s, push_mask_s;
  logic [23:0]   push_addr_s;

  // Lane merge of the incoming byte onto the accumulator (or onto zero for a fresh load)
  always_comb begin
    same_word_s   = acc_valid_q && (acc_addr_q == p4_address[25:2]);
    shift_s       = {p4_address[1:0], 3'b000};
    merged_data_s = ((same_word_s ? acc_data_q : 32'h0000_0000) & ~(32'h0000_00FF << shift_s))
                  | ({24'h00_0000, p4_wdata} << shift_s);
    merged_mask_s = (same_word_s ? acc_mask_q : 4'h0) | (4'b0001 << p4_address[1:0]);
  end

  // Accumulator next state, idle counter and push request
  always_comb begin
    acc_valid_d = acc_valid_q;
    acc_addr_d  = acc_addr_q;
    acc_data_d  = acc_data_q;
    acc_mask_d  = acc_mask_q;
    idle_cnt_d  = '0;
    push_s      = 1'b0;
    push_addr_s = acc_addr_q;
    push_data_s = acc_data_q;
    push_mask_s = acc_mask_q;
    if (p4_write) begin
      if (acc_valid_q && !same_word_s) begin
        push_s = 1'b1;
      end else begin
        push_s = push_s;
      end
      acc_addr_d = p4_address[25:2];
      if (merged_mask_s == 4'hF) begin
        push_s      = 1'b1;
        push_addr_s = p4_address[25:2];
        push_data_s = merged_data_s;
        push_mask_s = merged_mask_s;
        acc_valid_d = 1'b0;
      end else begin
        acc_valid_d = 1'b1;
        acc_data_d  = merged_data_s;
        acc_mask_d  = merged_mask_s;
      end
    end else if (acc_valid_q) begin
      // Fires on the idle cycle that brings the count to TIMEOUT-1
      if (flush || (idle_cnt_q == TO_FIRE)) begin
        push_s      = 1'b1;
        acc_valid_d = 1'b0;
      end else if (idle_cnt_q != TO_LAST) begin
        idle_cnt_d = idle_cnt_q + TW'(1);
      end else begin
        idle_cnt_d = idle_cnt_q;
      end
    end else begin
      idle_cnt_d = '0;
    end
  end

  // FIFO occupancy; a push into a full FIFO is accepted only alongside a pop
  always_comb begin
    pop_s     = (count_q != '0) && mem_ready;
    push_ok_s = push_s && ((count_q != DEPTH_C) || pop_s);
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_valid_q <= 1'b0;
      acc_addr_q  <= 24'h00_0000;
      acc_data_q  <= 32'h0000_0000;
      acc_mask_q  <= 4'h0;
      idle_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stall_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      acc_valid_q <= acc_valid_d;
      acc_addr_q  <= acc_addr_d;
      acc_data_q  <= acc_data_d;
      acc_mask_q  <= acc_mask_d;
      idle_cnt_q  <= idle_cnt_d;
      wr_ptr_q    <= push_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q    <= pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q     <= count_d;
      stall_q     <= (count_d >= STALL_TH);
      overflow_q  <= overflow_q | (push_s & ~push_ok_s);
    end
  end

  // FIFO storage (not reset)
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      fifo_addr_q[wr_ptr_q] <= push_addr_s;
      fifo_data_q[wr_ptr_q] <= push_data_s;
      fifo_mask_q[wr_ptr_q] <= push_mask_s;
    end
  end

  assign mem_valid   = (count_q != '0);
  assign mem_address = {fifo_addr_q[rd_ptr_q], 2'b00};
  assign mem_wdata   = fifo_data_q[rd_ptr_q];
  assign mem_wmask   = fifo_mask_q[rd_ptr_q];
  assign stall       = stall_q;
  assign overflow    = overflow_q;
  assign idle        = !acc_valid_q && (count_q == '0);

endmodule

// File: tb/tb_blit_write_combiner.sv
// Self-checking bench for blit_write_combiner: directed scenarios then random
// traffic, all compared each cycle against a transaction-level model.
module tb_blit_write_combiner;

  localparam int TIMEOUT = 16;
  localparam int DEPTH   = 8;
  localparam int MARGIN  = 4;

  logic        clock, reset_n, p4_write, flush, mem_ready;
  logic [25:0] p4_address;
  logic [7:0]  p4_wdata;
  logic        stall, idle, overflow, mem_valid;
  logic [25:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;

  blit_write_combiner #(.FIFO_DEPTH(DEPTH), .STALL_MARGIN(MARGIN), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n), .p4_write(p4_write), .p4_address(p4_address),
    .p4_wdata(p4_wdata), .flush(flush), .stall(stall), .idle(idle), .overflow(overflow),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [25:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } word_t;

  // Reference model: accumulator as a byte array plus the cycle of the last write
  word_t      mq[$];
  bit         m_acc_v;
  logic [23:0] m_acc_w;
  logic [7:0] m_bytes[4];
  logic [3:0] m_mask;
  int         m_last;
  int         cyc;
  bit         m_stall, m_ovf;
  int         n_checks, n_fail, pops;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic word_t acc_word();
    word_t w;
    w.a = {m_acc_w, 2'b00};
    w.d = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
    w.m = m_mask;
    return w;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_acc_v = 0; m_mask = 4'h0; m_stall = 0; m_ovf = 0;
    for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;
  endtask

  task automatic model_edge(input logic w, input logic [25:0] a, input logic [7:0] d,
                            input logic f, input logic r);
    bit    has_push;
    word_t pw;
    has_push = 0;
    if (w) begin
      if (m_acc_v && m_acc_w != a[25:2]) begin
        has_push = 1; pw = acc_word(); m_acc_v = 0;
      end
      if (!m_acc_v) begin
        m_acc_v = 1; m_acc_w = a[25:2]; m_mask = 4'h0;
        for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;
      end
      m_bytes[a[1:0]] = d;
      m_mask[a[1:0]]  = 1'b1;
      m_last = cyc;
      if (m_mask == 4'hF) begin
        has_push = 1; pw = acc_word(); m_acc_v = 0;
      end
    end else if (m_acc_v && (f || (cyc - m_last == TIMEOUT - 1))) begin
      has_push = 1; pw = acc_word(); m_acc_v = 0;
    end
    if (mq.size() != 0 && r) void'(mq.pop_front());
    if (has_push) begin
      if (mq.size() < DEPTH) mq.push_back(pw);
      else m_ovf = 1;
    end
    m_stall = (mq.size() >= DEPTH - MARGIN);
    cyc++;
  endtask

  task automatic step(input logic w, input logic [25:0] a, input logic [7:0] d,
                      input logic f, input logic r);
    p4_write = w; p4_address = a; p4_wdata = d; flush = f; mem_ready = r;
    #1;
    chk("mem_valid", mem_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("mem_address", mem_address, mq[0].a);
      chk("mem_wdata", mem_wdata, mq[0].d);
      chk("mem_wmask", mem_wmask, mq[0].m);
    end
    chk("idle", idle, !m_acc_v && mq.size() == 0);
    chk("stall", stall, m_stall);
    chk("overflow", overflow, m_ovf);
    if (mem_valid && r) pops++;
    model_edge(w, a, d, f, r);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    p4_write = 0; flush = 0; mem_ready = 0;
    reset_n = 0;
    #1;
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_stall", stall, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    model_clear();
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic full_words(input int first, input int n, input logic r);
    for (int k = 0; k < n; k++)
      for (int l = 0; l < 4; l++)
        step(1, 26'((first + k) * 4 + l), 8'((k * 16 + l) & 255), 0, r);
  endtask

  task automatic idle_steps(input int n, input logic f, input logic r);
    for (int k = 0; k < n; k++) step(0, 26'h0, 8'h00, f, r);
  endtask

  initial begin
    clock = 0; reset_n = 0; p4_write = 0; p4_address = '0; p4_wdata = '0;
    flush = 0; mem_ready = 0;
    n_checks = 0; n_fail = 0; cyc = 0; m_last = 0; pops = 0; m_acc_w = '0;
    do_reset();

    // Four bytes of one word
    step(1, 26'h100, 8'h11, 0, 1);
    step(1, 26'h101, 8'h22, 0, 1);
    step(1, 26'h102, 8'h33, 0, 1);
    step(1, 26'h103, 8'h44, 0, 1);
    chk("full_word_valid", mem_valid, 1'b1);
    chk("full_word_data", mem_wdata, 32'h4433_2211);
    idle_steps(3, 0, 1);

    // Word change pushes the old word, then the new one times out
    step(1, 26'h201, 8'hAA, 0, 1);
    step(1, 26'h301, 8'hBB, 0, 1);
    chk("word_change_data", mem_wdata, 32'h0000_AA00);
    idle_steps(TIMEOUT + 3, 0, 1);

    // Same-lane overwrite then flush
    step(1, 26'h402, 8'h5A, 0, 0);
    step(1, 26'h402, 8'hA5, 0, 0);
    idle_steps(2, 1, 0);
    idle_steps(3, 1, 1);
    chk("flush_idle", idle, 1'b1);

    // Overflow with stall ignored, then drain
    full_words(26'h1000, 9, 0);
    chk("overflow_set", overflow, 1'b1);
    pops = 0;
    idle_steps(12, 0, 1);
    chk("drain_pops", pops, 8);

    // Push and pop together while full
    do_reset();
    full_words(26'h2000, 8, 0);
    step(1, 26'h8000, 8'h01, 0, 0);
    step(1, 26'h8001, 8'h02, 0, 0);
    step(1, 26'h8002, 8'h03, 0, 0);
    step(1, 26'h8003, 8'h04, 0, 1);
    chk("full_pushpop_ovf", overflow, 1'b0);
    idle_steps(12, 0, 1);

    // Reset mid-operation discards everything
    full_words(26'h3000, 3, 0);
    step(1, 26'h9001, 8'h77, 0, 0);
    do_reset();
    idle_steps(TIMEOUT + 4, 0, 1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        w, f, r;
      logic [23:0] word;
      int          sel;
      if (((i / 64) % 4) == 3) w = ($urandom_range(0, 31) == 0);
      else                     w = ($urandom_range(0, 3) != 0);
      sel  = $urandom_range(0, 3);
      word = (sel < 3) ? 24'(24'h40 + sel) : 24'($urandom);
      f    = ($urandom_range(0, 15) == 0);
      r    = ($urandom_range(0, 3) != 0);
      step(w, {word, 2'($urandom_range(0, 3))}, 8'($urandom), f, r);
    end
    idle_steps(TIMEOUT + DEPTH + 4, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/blit_write_combiner.md
# blit_write_combiner

Final stage of the blitter pipeline, directly downstream of the color/transparency stage. It takes that stage's per-pixel byte writes (`p4_write`/`p4_address`/`p4_wdata`) and merges consecutive bytes that fall in the same 32-bit word into one masked word write. Merged words are buffered in a small FIFO and presented to the memory arbiter over a valid/ready handshake. The blitter pipeline has no backpressure of its own, so this block exports an early `stall` that upstream uses to freeze pixel issue.

## Interface
- FIFO_DEPTH, 8, word-write FIFO entries; power of two, minimum 4.
- STALL_MARGIN, 4, free-entry threshold for `stall`; must be at least the number of pixels in flight upstream of `p4`.
- TIMEOUT, 16, idle cycles after which a partial word is auto-flushed; minimum 2.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- p4_write  in  1  byte write valid this cycle.
- p4_address  in  26  byte address.
- p4_wdata  in  8  byte data.
- flush  in  1  level; drains the partial word while high.
- stall  out  1  upstream must stop issuing pixels.
- idle  out  1  no partial word held and FIFO empty.
- overflow  out  1  sticky error: a push was dropped.
- mem_valid  out  1  word write available.
- mem_ready  in  1  arbiter accepts the word.
- mem_address  out  26  word address; bits [1:0] are always 0.
- mem_wdata  out  32  write data, little-endian lanes.
- mem_wmask  out  4  byte enables; bit n enables bits [8n+7:8n].

## Operation
- Accumulator state: `acc_valid`, `acc_addr[25:2]`, `acc_data[31:0]`, `acc_mask[3:0]`. Lane = `p4_address[1:0]`.
- When `p4_write` is high, exactly one of these cases applies:
  - Accumulator empty: load the byte into its lane and set the mask to onehot(lane).
  - Accumulator valid and same word: overwrite the lane and OR in the mask bit. A later byte to the same lane wins.
  - Accumulator valid and different word: push the old accumulator, then load the new byte as in the empty case.
  - Full-word rule: if a merge or load makes the mask 4'hF, push the merged word this cycle and clear `acc_valid`.
- When `p4_write` is low and `acc_valid` is high:
  - If `flush` is high, or the idle counter has reached TIMEOUT-1, push the accumulator and clear it.
- Idle counter:
  - Reset to 0 on any `p4_write` and whenever `acc_valid` is 0.
  - Otherwise increment, saturating at TIMEOUT-1.
- At most one push occurs per cycle, by construction.
- FIFO behaviour:
  - First-word-fall-through: `mem_*` show the head entry and `mem_valid` = (count != 0).
  - Pop occurs when `mem_valid && mem_ready`.
  - A push is accepted if count < FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the push is dropped, `overflow` is set and stays set until reset, and the accumulator still updates as if the push succeeded.
- Count width is $clog2(FIFO_DEPTH)+1; the count wraps never, the pointers wrap modulo FIFO_DEPTH.
- `stall` is registered: next value = (next_count >= FIFO_DEPTH - STALL_MARGIN).
- `idle` is combinational: !acc_valid && count == 0.
- `mem_address`, `mem_wdata` and `mem_wmask` are unspecified while `mem_valid` is 0; FIFO storage is not reset.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system): `acc_valid`=0, count=0, pointers=0, idle counter=0, `mem_valid`=0, `stall`=0, `idle`=1, `overflow`=0.
- Reset mid-operation discards the partial word and all FIFO contents; no write is emitted.
- Push latency:
  - A push caused by the cycle-N input is visible as `mem_valid`=1 in cycle N+1, when the FIFO was empty.
  - Otherwise the word appears behind the existing entries.
- Timeout: a last write in cycle N with no further writes and `flush` low produces a push at the end of cycle N+TIMEOUT-1, so `mem_valid` rises in cycle N+TIMEOUT.
- Flush: with `flush` high and no write, a held partial word is pushed in the same cycle; `idle` can rise only after the FIFO drains.
- `stall` reflects the FIFO state one cycle after the push or pop that changed it.
- Handshake: once asserted, `mem_valid` and the head data hold until `mem_ready`. `mem_ready` with `mem_valid` low has no effect.

## Test plan
- Four writes to 0x100..0x103 with data 11, 22, 33, 44 on consecutive cycles, `mem_ready`=1 → one word: address 0x100, data 0x44332211, mask F, `mem_valid` in the cycle after the fourth write.
- Writes to 0x201 (AA), then 0x301 (BB), then idle → 0x200 / 0x0000AA00 / mask 2 the cycle after the second write; 0x300 / mask 2 TIMEOUT cycles after the second write.
- Writes to 0x402 (5A) then 0x402 (A5), then `flush` high → a single word 0x400, mask 4, data[23:16]=A5; `idle` goes to 1 after the pop.
- `mem_ready`=0 while full words are pushed continuously → `stall` rises when count reaches 4 (FIFO_DEPTH=8). Ignoring `stall` until 9 pushes → `overflow`=1 and exactly 8 words are later popped, in order.
- Push and pop in the same cycle at count=8 with `mem_ready`=1 → the push is accepted, count stays 8, `overflow` stays 0.
- `reset_n` pulsed low with 3 entries queued and a partial word held → `mem_valid`=0 and `idle`=1 immediately; no further word is emitted.
